// File: rtl/rf_wr_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wr_arbiter
//
// Round-robin arbiter that shares the register file's two write ports (A, B)
// among NREQ writeback requesters. Each cycle it grants up to two requesters
// with distinct nonzero destinations. It registers those grants onto the
// we/wa/wd port outputs. Writes to x0 are accepted and dropped without using
// a port.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   freeze     blocks every acceptance this cycle
//   req_valid  per-requester write pending
//   req_addr   per-requester destination register (5 bits each)
//   req_data   per-requester write data (XLEN bits each)
//   req_ready  combinational accept; a transfer happens on valid & ready
//   we_a/wa_a/wd_a  registered write port A
//   we_b/wa_b/wd_b  registered write port B
//   rr_ptr     current round-robin start index (debug)
// -----------------------------------------------------------------------------
module rf_wr_arbiter #(
  parameter int XLEN = 32,
  parameter int NREQ = 4,
  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      freeze,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0][4:0]      req_addr,
  input  logic [NREQ-1:0][XLEN-1:0] req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      we_a,
  output logic [4:0]                wa_a,
  output logic [XLEN-1:0]           wd_a,
  output logic                      we_b,
  output logic [4:0]                wa_b,
  output logic [XLEN-1:0]           wd_b,
  output logic [PW-1:0]             rr_ptr
);

  localparam logic [PW:0] NREQ_W = (PW+1)'(NREQ);

  // (base + off) mod NREQ. One extra bit of headroom is enough because both
  // operands are below NREQ, so a single conditional subtract wraps it.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base,
                                             input logic [PW:0]   off);
    logic [PW:0] sum;
    // NOTE: functions and always_comb use blocking '='; only always_ff
    // state uses non-blocking '<='.
    sum = {1'b0, base} + off;
    if (sum >= NREQ_W) sum = sum - NREQ_W;
    return sum[PW-1:0];
  endfunction

  logic [NREQ-1:0] addr_zero;
  logic [NREQ-1:0] elig;
  logic            gnt_a_vld;
  logic            gnt_b_vld;
  logic [PW-1:0]   gnt_a_idx;
  logic [PW-1:0]   gnt_b_idx;
  logic [NREQ-1:0] gnt_oh;
  logic [PW-1:0]   last_idx;

  always_comb begin
    addr_zero = '0;
    for (int i = 0; i < NREQ; i++) addr_zero[i] = (req_addr[i] == 5'd0);
  end

  assign elig = req_valid & ~addr_zero;

  // Walk the requesters starting at rr_ptr. The first eligible one takes
  // port A. The next eligible one with a different destination takes port B.
  // A requester that matches A's destination is skipped and stays pending, so
  // the two ports never write the same register in one cycle.
  always_comb begin
    logic [PW-1:0] idx;
    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch.
    idx       = '0;
    gnt_a_vld = 1'b0;
    gnt_b_vld = 1'b0;
    gnt_a_idx = '0;
    gnt_b_idx = '0;
    gnt_oh    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = wrap_add(rr_ptr, (PW+1)'(k));
      if (elig[idx]) begin
        if (!gnt_a_vld) begin
          gnt_a_vld   = 1'b1;
          gnt_a_idx   = idx;
          gnt_oh[idx] = 1'b1;
        end else if (!gnt_b_vld && (req_addr[idx] != req_addr[gnt_a_idx])) begin
          gnt_b_vld   = 1'b1;
          gnt_b_idx   = idx;
          gnt_oh[idx] = 1'b1;
        end
      end
    end
  end

  // x0 writes are always absorbed, even when req_valid is low. This is harmless,
  // because a transfer needs valid & ready. Ready is held low while in reset.
  assign req_ready = {NREQ{rst_n & ~freeze}} & (gnt_oh | addr_zero);

  // The pointer advances past the last port grant, which is B when present.
  assign last_idx = gnt_b_vld ? gnt_b_idx : gnt_a_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_a   <= 1'b0;
      wa_a   <= '0;
      wd_a   <= '0;
      we_b   <= 1'b0;
      wa_b   <= '0;
      wd_b   <= '0;
      rr_ptr <= '0;
    end else begin
      we_a <= gnt_a_vld & ~freeze;
      we_b <= gnt_b_vld & ~freeze;
      // An unused port keeps its last address and data. Only we drops.
      if (gnt_a_vld && !freeze) begin
        wa_a <= req_addr[gnt_a_idx];
        wd_a <= req_data[gnt_a_idx];
      end
      if (gnt_b_vld && !freeze) begin
        wa_b <= req_addr[gnt_b_idx];
        wd_b <= req_data[gnt_b_idx];
      end
      if (gnt_a_vld && !freeze) rr_ptr <= wrap_add(last_idx, (PW+1)'(1));
    end
  end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_wr_arbiter
//
// Self-checking bench for rf_wr_arbiter with XLEN=32 and NREQ=4. Each stimulus
// cycle runs a reference model of the grant rules. The model pushes the
// expected registered port state and rr_ptr onto a scoreboard queue. The
// bench pops that entry and compares it one cycle later. Each scenario task
// also makes its own direct checks against hand-derived values.
// -----------------------------------------------------------------------------
module tb_rf_wr_arbiter;

  localparam int XLEN = 32;
  localparam int NREQ = 4;
  localparam int PW   = 2;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      freeze = 1'b0;
  logic [NREQ-1:0]           req_valid = '0;
  logic [NREQ-1:0][4:0]      req_addr = '0;
  logic [NREQ-1:0][XLEN-1:0] req_data = '0;
  logic [NREQ-1:0]           req_ready;
  logic                      we_a, we_b;
  logic [4:0]                wa_a, wa_b;
  logic [XLEN-1:0]           wd_a, wd_b;
  logic [PW-1:0]             rr_ptr;

  rf_wr_arbiter #(.XLEN(XLEN), .NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .rr_ptr(rr_ptr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            we_a;
    logic [4:0]      wa_a;
    logic [XLEN-1:0] wd_a;
    logic            we_b;
    logic [4:0]      wa_b;
    logic [XLEN-1:0] wd_b;
    logic [PW-1:0]   ptr;
  } port_state_t;

  port_state_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int              m_ptr = 0;
  logic [4:0]      m_wa_a = '0, m_wa_b = '0;
  logic [XLEN-1:0] m_wd_a = '0, m_wd_b = '0;

  // The model builds the search order explicitly. It then picks A and B from
  // that list.
  task automatic model_grant(output int ga, output int gb);
    int order[NREQ];
    for (int k = 0; k < NREQ; k++) order[k] = (m_ptr + k) % NREQ;
    ga = -1;
    gb = -1;
    foreach (order[k]) begin
      if (ga < 0 && req_valid[order[k]] && req_addr[order[k]] != 5'd0)
        ga = order[k];
    end
    if (ga >= 0) begin
      foreach (order[k]) begin
        if (gb < 0 && order[k] != ga && req_valid[order[k]] &&
            req_addr[order[k]] != 5'd0 && req_addr[order[k]] != req_addr[ga])
          gb = order[k];
      end
      // The search for B must start after A. The list above starts at m_ptr
      // and A is the first eligible entry, so every candidate lies after A.
    end
  endtask

  function automatic void model_reset();
    m_ptr  = 0;
    m_wa_a = '0; m_wd_a = '0;
    m_wa_b = '0; m_wd_b = '0;
    sb.delete();
  endfunction

  // One clock cycle with the inputs already driven. The task checks
  // req_ready mid-cycle, pushes the expected port state, then pops and
  // compares it after the edge. It also checks the write-port invariants.
  task automatic run_cycle(input string name);
    int ga, gb;
    logic [NREQ-1:0] exp_rdy;
    port_state_t e, got;
    #1;
    model_grant(ga, gb);
    exp_rdy = '0;
    for (int i = 0; i < NREQ; i++)
      if (!freeze && (i == ga || i == gb || req_addr[i] == 5'd0)) exp_rdy[i] = 1'b1;
    n_checks++;
    if (req_ready !== exp_rdy)
      $display("FAIL %s.ready: got %b expected %b", name, req_ready, exp_rdy);
    else n_pass++;

    e = '0;
    if (!freeze && ga >= 0) begin
      e.we_a = 1'b1; m_wa_a = req_addr[ga]; m_wd_a = req_data[ga];
    end
    if (!freeze && gb >= 0) begin
      e.we_b = 1'b1; m_wa_b = req_addr[gb]; m_wd_b = req_data[gb];
    end
    if (!freeze && ga >= 0) m_ptr = (((gb >= 0) ? gb : ga) + 1) % NREQ;
    e.wa_a = m_wa_a; e.wd_a = m_wd_a;
    e.wa_b = m_wa_b; e.wd_b = m_wd_b;
    e.ptr  = PW'(m_ptr);
    sb.push_back(e);

    @(posedge clk);
    #1;
    got = '{we_a, wa_a, wd_a, we_b, wa_b, wd_b, rr_ptr};
    e = sb.pop_front();
    n_checks++;
    if (got !== e)
      $display("FAIL %s.ports: got %h expected %h", name, got, e);
    else n_pass++;
    n_checks++;
    if ((we_a && we_b && wa_a == wa_b) || (we_a && wa_a == 5'd0) || (we_b && wa_b == 5'd0))
      $display("FAIL %s.invariant: got we_a=%b wa_a=%0d we_b=%b wa_b=%0d expected distinct nonzero",
               name, we_a, wa_a, we_b, wa_b);
    else n_pass++;
  endtask

  task automatic clear_inputs();
    freeze    = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    // Reset held from time zero; requests present must not be accepted.
    req_valid = '1;
    req_addr  = {5'd4, 5'd3, 5'd2, 5'd1};
    #3;
    n_checks++;
    if (req_ready !== '0 || we_a !== 1'b0 || we_b !== 1'b0 || rr_ptr !== '0 ||
        wa_a !== '0 || wd_a !== '0 || wa_b !== '0 || wd_b !== '0)
      $display("FAIL reset.initial: got rdy=%b we_a=%b we_b=%b ptr=%0d expected all zero",
               req_ready, we_a, we_b, rr_ptr);
    else n_pass++;
    do_reset();

    // Mid-run: launch a write, then pull reset while we_a is high.
    req_valid[0] = 1'b1; req_addr[0] = 5'd9; req_data[0] = 32'h1234_5678;
    run_cycle("reset.prime");
    n_checks++;
    if (we_a !== 1'b1)
      $display("FAIL reset.we_a_before: got %b expected 1", we_a);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (we_a !== 1'b0 || we_b !== 1'b0)
      $display("FAIL reset.async_drop: got we_a=%b we_b=%b expected 0 0", we_a, we_b);
    else n_pass++;
    clear_inputs();
    model_reset();
    #2;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (rr_ptr !== '0 || wa_a !== '0 || wd_a !== '0 || wa_b !== '0 || wd_b !== '0)
      $display("FAIL reset.after: got ptr=%0d wa_a=%0d wd_a=%h wa_b=%0d wd_b=%h expected zeros",
               rr_ptr, wa_a, wd_a, wa_b, wd_b);
    else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    req_valid[0] = 1'b1; req_addr[0] = 5'd5; req_data[0] = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if (req_ready[0] !== 1'b1)
      $display("FAIL single.ready0: got %b expected 1", req_ready[0]);
    else n_pass++;
    run_cycle("single");
    n_checks++;
    if (we_a !== 1'b1 || wa_a !== 5'd5 || wd_a !== 32'hDEAD_BEEF || we_b !== 1'b0 || rr_ptr !== 2'd1)
      $display("FAIL single.out: got we_a=%b wa_a=%0d wd_a=%h we_b=%b ptr=%0d expected 1 5 deadbeef 0 1",
               we_a, wa_a, wd_a, we_b, rr_ptr);
    else n_pass++;
    clear_inputs();
  endtask

  task automatic test_all_four();
    do_reset();
    req_valid = '1;
    req_addr  = {5'd4, 5'd3, 5'd2, 5'd1};
    req_data  = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    run_cycle("all4.c1");
    n_checks++;
    if (wa_a !== 5'd1 || wa_b !== 5'd2 || !we_a || !we_b || rr_ptr !== 2'd2)
      $display("FAIL all4.c1: got wa_a=%0d wa_b=%0d ptr=%0d expected 1 2 2", wa_a, wa_b, rr_ptr);
    else n_pass++;
    run_cycle("all4.c2");
    n_checks++;
    if (wa_a !== 5'd3 || wa_b !== 5'd4 || !we_a || !we_b || rr_ptr !== 2'd0)
      $display("FAIL all4.c2: got wa_a=%0d wa_b=%0d ptr=%0d expected 3 4 0", wa_a, wa_b, rr_ptr);
    else n_pass++;
    clear_inputs();
  endtask

  task automatic test_conflict();
    do_reset();
    req_valid = 4'b0111;
    req_addr  = {5'd0, 5'd9, 5'd7, 5'd7};
    req_data  = {32'h0, 32'hC2, 32'hC1, 32'hC0};
    #1;
    n_checks++;
    if (req_ready[2:0] !== 3'b101)
      $display("FAIL conflict.ready: got %b expected 101", req_ready[2:0]);
    else n_pass++;
    run_cycle("conflict.c1");
    n_checks++;
    if (wa_a !== 5'd7 || wd_a !== 32'hC0 || wa_b !== 5'd9 || rr_ptr !== 2'd3)
      $display("FAIL conflict.c1: got wa_a=%0d wd_a=%h wa_b=%0d ptr=%0d expected 7 c0 9 3",
               wa_a, wd_a, wa_b, rr_ptr);
    else n_pass++;
    req_valid = 4'b0010;
    run_cycle("conflict.c2");
    n_checks++;
    if (we_a !== 1'b1 || wa_a !== 5'd7 || wd_a !== 32'hC1 || we_b !== 1'b0)
      $display("FAIL conflict.c2: got we_a=%b wa_a=%0d wd_a=%h we_b=%b expected 1 7 c1 0",
               we_a, wa_a, wd_a, we_b);
    else n_pass++;
    clear_inputs();
  endtask

  task automatic test_x0();
    do_reset();
    req_valid = 4'b0110;
    req_addr  = {5'd11, 5'd3, 5'd0, 5'd10};
    req_data  = {32'h0, 32'hA2, 32'hA1, 32'h0};
    #1;
    n_checks++;
    if (req_ready !== 4'b0110)
      $display("FAIL x0.ready: got %b expected 0110", req_ready);
    else n_pass++;
    run_cycle("x0.c1");
    n_checks++;
    if (we_a !== 1'b1 || wa_a !== 5'd3 || we_b !== 1'b0 || rr_ptr !== 2'd3)
      $display("FAIL x0.c1: got we_a=%b wa_a=%0d we_b=%b ptr=%0d expected 1 3 0 3",
               we_a, wa_a, we_b, rr_ptr);
    else n_pass++;
    req_valid = 4'b0010;
    run_cycle("x0.only");
    n_checks++;
    if (we_a !== 1'b0 || we_b !== 1'b0 || rr_ptr !== 2'd3)
      $display("FAIL x0.only: got we_a=%b we_b=%b ptr=%0d expected 0 0 3", we_a, we_b, rr_ptr);
    else n_pass++;
    clear_inputs();
  endtask

  task automatic test_freeze();
    do_reset();
    req_valid = 4'b0001; req_addr[0] = 5'd8; req_data[0] = 32'hF0;
    run_cycle("freeze.pre");
    req_valid = '1;
    req_addr  = {5'd4, 5'd3, 5'd2, 5'd1};
    req_data  = {32'hF3, 32'hF2, 32'hF1, 32'hF0};
    freeze    = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== '0)
      $display("FAIL freeze.ready: got %b expected 0000", req_ready);
    else n_pass++;
    run_cycle("freeze.hold");
    n_checks++;
    if (we_a !== 1'b0 || we_b !== 1'b0 || rr_ptr !== 2'd1)
      $display("FAIL freeze.hold: got we_a=%b we_b=%b ptr=%0d expected 0 0 1", we_a, we_b, rr_ptr);
    else n_pass++;
    freeze = 1'b0;
    run_cycle("freeze.resume");
    n_checks++;
    if (wa_a !== 5'd2 || wa_b !== 5'd3 || rr_ptr !== 2'd3)
      $display("FAIL freeze.resume: got wa_a=%0d wa_b=%0d ptr=%0d expected 2 3 3", wa_a, wa_b, rr_ptr);
    else n_pass++;
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    // The same register is written in consecutive cycles. The later value
    // must leave the port one cycle after the earlier one.
    do_reset();
    req_valid = 4'b0001; req_addr[0] = 5'd12; req_data[0] = 32'h1111;
    run_cycle("b2b.c1");
    req_data[0] = 32'h2222;
    run_cycle("b2b.c2");
    n_checks++;
    if (we_a !== 1'b1 || wa_a !== 5'd12 || wd_a !== 32'h2222)
      $display("FAIL b2b.later: got we_a=%b wa_a=%0d wd_a=%h expected 1 12 2222", we_a, wa_a, wd_a);
    else n_pass++;
    clear_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 300; c++) begin
      freeze    = ($urandom_range(0, 7) == 0);
      req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        req_addr[i] = 5'($urandom_range(0, 6));
        req_data[i] = $urandom;
      end
      run_cycle("random");
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_conflict();
    test_x0();
    test_freeze();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
